mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, data and address width in bits.
REQ-002 Parameter: MAXLOCK, default 8, max consecutive locked DMA beats before the CPU wins the next tie.
REQ-003 clk  input  1  rising-edge clock; sole clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 CpuReq  input  1  CPU access request; held stable until CpuDone.
REQ-006 CpuWe  input  1  CPU write enable, qualified by CpuReq.
REQ-007 CpuAdr  input  WIDTH  CPU byte address.
REQ-008 CpuWData  input  WIDTH  CPU write data.
REQ-009 CpuRData  output  WIDTH  registered CPU read data.
REQ-010 CpuDone  output  1  one-cycle CPU completion pulse.
REQ-011 DmaReq, DmaWe, DmaAdr, DmaWData  input  1,1,WIDTH,WIDTH  DMA request fields, same rules as CPU.
REQ-012 DmaLast  input  1  marks the final beat of a DMA burst.
REQ-013 DmaRData  output  WIDTH  registered DMA read data.
REQ-014 DmaDone  output  1  one-cycle DMA completion pulse.
REQ-015 MemAdr, MemWData  output  WIDTH  shared memory address and write data.
REQ-016 MemWrite  output  1  shared memory write strobe.
REQ-017 MemRData  input  WIDTH  memory read data, combinational from MemAdr.
REQ-018 Owner  output  2  00 none, 01 CPU, 10 DMA; 11 never driven.

Function
REQ-019 FSM states IDLE, CACC, DACC, RESP; every access is exactly IDLE -> xACC -> RESP -> IDLE (3 cycles).
REQ-020 IDLE: only CpuReq -> CACC; only DmaReq -> DACC; neither -> stay IDLE.
REQ-021 IDLE, both requesting: Lock=1 and LockCnt<MAXLOCK -> DACC; otherwise grant the requester not in LastOwner.
REQ-022 CACC/DACC: MemAdr/MemWData = granted requester's Adr/WData, MemWrite = granted We, Owner = 01/10; next state RESP.
REQ-023 Outside CACC/DACC: MemAdr=0, MemWData=0, MemWrite=0, Owner=00.
REQ-024 End of xACC cycle: on a read, MemRData is captured into the granted requester's RData; on a write, RData is unchanged; LastOwner is updated.
REQ-025 RESP: pulse the granted requester's Done for exactly one cycle; the other Done stays 0; next state IDLE.
REQ-026 Requests are ignored in RESP; a Req still high in the following IDLE is a new request (back-to-back rate: 1 access per 3 cycles).
REQ-027 RData holds its value until the next read completion for the same requester.
REQ-028 DMA lock on DACC completion:
  - DmaLast=0: Lock=1, LockCnt+1, saturating at MAXLOCK.
  - DmaLast=1: Lock=0, LockCnt=0.
REQ-029 CACC completion sets LockCnt=0 but leaves Lock unchanged.
REQ-030 Lock affects tie-breaking only; a lone CPU request is always granted.
REQ-031 Request fields are sampled only in xACC; changes outside xACC have no effect.

Reset
REQ-032 reset high at a rising edge forces, from any state:
  - state IDLE
  - Lock=0, LockCnt=0, LastOwner=DMA (so the CPU wins the first tie)
  - CpuRData=0, DmaRData=0, CpuDone=0, DmaDone=0
REQ-033 MemWrite is gated by ~reset, so a write in progress when reset asserts is suppressed in that same cycle.
REQ-034 An access interrupted by reset produces no Done pulse.

Verification
REQ-035 CPU read: CpuReq=1, CpuAdr=0x10, MemRData=0xE3A00005 -> Owner=01 in cycle 2, CpuDone pulse in cycle 3, CpuRData=0xE3A00005, DmaDone=0 throughout.
REQ-036 DMA write: DmaReq=1, DmaWe=1, DmaAdr=0x64, DmaWData=7 -> MemWrite=1, MemAdr=0x64, MemWData=7 for exactly one cycle, DmaDone next cycle, DmaRData unchanged.
REQ-037 Tie after reset, both Req held: grants alternate CPU, DMA, CPU; each Done pulses once per grant.
REQ-038 DMA burst with DmaLast=0 and CPU requesting: first tie -> CPU; then 8 consecutive DMA grants; then CPU wins; DmaLast=1 on a later beat -> Lock=0.
REQ-039 reset asserted during CACC of a CPU write -> MemWrite=0 that cycle, no CpuDone, IDLE next cycle, all outputs at reset values.
REQ-040 Req dropped in RESP and re-raised 2 cycles later -> new grant in the IDLE cycle where it is seen; no spurious Done pulse.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared bus between the CPU port, the DMA port, the memory port and the arbiter.
// The arbiter takes the slave view; the requesters and the memory take the master view.
interface mem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             CpuReq;
    logic             CpuWe;
    logic [WIDTH-1:0] CpuAdr;
    logic [WIDTH-1:0] CpuWData;
    logic [WIDTH-1:0] CpuRData;
    logic             CpuDone;

    logic             DmaReq;
    logic             DmaWe;
    logic [WIDTH-1:0] DmaAdr;
    logic [WIDTH-1:0] DmaWData;
    logic             DmaLast;
    logic [WIDTH-1:0] DmaRData;
    logic             DmaDone;

    logic [WIDTH-1:0] MemAdr;
    logic [WIDTH-1:0] MemWData;
    logic             MemWrite;
    logic [WIDTH-1:0] MemRData;
    logic [1:0]       Owner;

    modport slave (
        input  CpuReq, CpuWe, CpuAdr, CpuWData,
        input  DmaReq, DmaWe, DmaAdr, DmaWData, DmaLast,
        input  MemRData,
        output CpuRData, CpuDone, DmaRData, DmaDone,
        output MemAdr, MemWData, MemWrite, Owner
    );

    modport master (
        output CpuReq, CpuWe, CpuAdr, CpuWData,
        output DmaReq, DmaWe, DmaAdr, DmaWData, DmaLast,
        output MemRData,
        input  CpuRData, CpuDone, DmaRData, DmaDone,
        input  MemAdr, MemWData, MemWrite, Owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) single-port memory arbiter; every access takes IDLE -> xACC -> RESP.
// DMA bursts may lock the bus for up to MAXLOCK beats before the CPU wins a tie again.
//
// state | meaning
// IDLE  | waiting for a request, arbitration happens here
// CACC  | CPU owns the memory port for one cycle
// DACC  | DMA owns the memory port for one cycle
// RESP  | Done pulse to the granted requester, requests ignored
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int MAXLOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(MAXLOCK + 1);

    typedef enum logic [1:0] {IDLE, CACC, DACC, RESP} state_t;

    state_t           state_q, state_d;
    logic             lock_q, lock_d;
    logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
    logic             last_dma_q, last_dma_d;
    logic [WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [WIDTH-1:0] dma_rdata_q, dma_rdata_d;
    logic             cpu_done_q, cpu_done_d;
    logic             dma_done_q, dma_done_d;
    logic [1:0]       owner_q, owner_d;

    logic [WIDTH-1:0] mem_adr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_write;

    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        lock_cnt_d  = lock_cnt_q;
        last_dma_d  = last_dma_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_done_d  = 1'b0;
        dma_done_d  = 1'b0;
        owner_d     = 2'b00;

        case (state_q)
            IDLE: begin
                if (bus.CpuReq && bus.DmaReq) begin
                    // An active lock under its beat limit keeps the bus with DMA.
                    if (lock_q && (lock_cnt_q < CW'(MAXLOCK)))
                        state_d = DACC;
                    else if (last_dma_q)
                        state_d = CACC;
                    else
                        state_d = DACC;
                end else if (bus.CpuReq) begin
                    state_d = CACC;
                end else if (bus.DmaReq) begin
                    state_d = DACC;
                end
            end
            CACC: begin
                state_d    = RESP;
                if (!bus.CpuWe)
                    cpu_rdata_d = bus.MemRData;
                lock_cnt_d = '0;
                last_dma_d = 1'b0;
                cpu_done_d = 1'b1;
            end
            DACC: begin
                state_d = RESP;
                if (!bus.DmaWe)
                    dma_rdata_d = bus.MemRData;
                if (bus.DmaLast) begin
                    lock_d     = 1'b0;
                    lock_cnt_d = '0;
                end else begin
                    lock_d = 1'b1;
                    if (lock_cnt_q < CW'(MAXLOCK))
                        lock_cnt_d = lock_cnt_q + 1'b1;
                end
                last_dma_d = 1'b1;
                dma_done_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == CACC)
            owner_d = 2'b01;
        else if (state_d == DACC)
            owner_d = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lock_q      <= 1'b0;
            lock_cnt_q  <= '0;
            last_dma_q  <= 1'b1;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            owner_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            lock_cnt_q  <= lock_cnt_d;
            last_dma_q  <= last_dma_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_done_q  <= cpu_done_d;
            dma_done_q  <= dma_done_d;
            owner_q     <= owner_d;
        end
    end

    // Memory port follows the live request fields so they are only sampled during xACC.
    always_comb begin
        mem_adr   = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        if (state_q == CACC) begin
            mem_adr   = bus.CpuAdr;
            mem_wdata = bus.CpuWData;
            mem_write = bus.CpuWe & ~reset;
        end else if (state_q == DACC) begin
            mem_adr   = bus.DmaAdr;
            mem_wdata = bus.DmaWData;
            mem_write = bus.DmaWe & ~reset;
        end
    end

    assign bus.MemAdr   = mem_adr;
    assign bus.MemWData = mem_wdata;
    assign bus.MemWrite = mem_write;
    assign bus.Owner    = owner_q;
    assign bus.CpuRData = cpu_rdata_q;
    assign bus.DmaRData = dma_rdata_q;
    assign bus.CpuDone  = cpu_done_q;
    assign bus.DmaDone  = dma_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic,
// all compared cycle by cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
    logic clk;
    logic reset;

    int n_assert = 0;
    int n_fail   = 0;

    mem_arbiter_if #(.WIDTH(32)) bus();

    mem_arbiter #(.WIDTH(32), .MAXLOCK(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10)
            return 32'hE3A0_0005;
        return (a * 32'h0100_0193) ^ 32'hA5A5_0F0F;
    endfunction

    assign bus.MemRData = mem_fn(bus.MemAdr);

    // access model: phase 0 waiting, 1 memory cycle, 2 done cycle
    int          m_ph;
    bit          m_dma;
    bit          m_lock;
    int          m_cnt;
    bit          m_last_dma;
    logic [31:0] m_cpu_rd;
    logic [31:0] m_dma_rd;

    bit         rec_en = 1'b0;
    logic [1:0] grants[$];

    logic [1:0] exp37 [3]  = '{2'b01, 2'b10, 2'b01};
    logic [1:0] exp38 [13] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                               2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph       = 0;
        m_dma      = 1'b0;
        m_lock     = 1'b0;
        m_cnt      = 0;
        m_last_dma = 1'b1;
        m_cpu_rd   = '0;
        m_dma_rd   = '0;
    endtask

    task automatic step();
        logic [31:0] e_adr, e_wd;
        logic        e_wr;
        logic [1:0]  e_own;
        logic        we_s;
        logic [31:0] adr_s;
        #1;
        e_adr = '0; e_wd = '0; e_wr = 1'b0; e_own = 2'b00;
        if (m_ph == 1) begin
            e_own = m_dma ? 2'b10 : 2'b01;
            e_adr = m_dma ? bus.DmaAdr : bus.CpuAdr;
            e_wd  = m_dma ? bus.DmaWData : bus.CpuWData;
            e_wr  = (m_dma ? bus.DmaWe : bus.CpuWe) & ~reset;
        end
        check("owner",     32'(bus.Owner), 32'(e_own));
        check("mem_adr",   bus.MemAdr, e_adr);
        check("mem_wdata", bus.MemWData, e_wd);
        check("mem_write", 32'(bus.MemWrite), 32'(e_wr));
        check("cpu_done",  32'(bus.CpuDone), 32'((m_ph == 2) && !m_dma));
        check("dma_done",  32'(bus.DmaDone), 32'((m_ph == 2) && m_dma));
        check("cpu_rdata", bus.CpuRData, m_cpu_rd);
        check("dma_rdata", bus.DmaRData, m_dma_rd);
        if (rec_en && bus.Owner != 2'b00)
            grants.push_back(bus.Owner);

        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (m_ph == 0) begin
            if (bus.CpuReq && bus.DmaReq) begin
                m_dma = (m_lock && m_cnt < 8) ? 1'b1 : !m_last_dma;
                m_ph  = 1;
            end else if (bus.CpuReq || bus.DmaReq) begin
                m_dma = bus.DmaReq;
                m_ph  = 1;
            end
        end else if (m_ph == 1) begin
            we_s  = m_dma ? bus.DmaWe : bus.CpuWe;
            adr_s = m_dma ? bus.DmaAdr : bus.CpuAdr;
            if (!we_s) begin
                if (m_dma) m_dma_rd = mem_fn(adr_s);
                else       m_cpu_rd = mem_fn(adr_s);
            end
            if (m_dma) begin
                if (bus.DmaLast) begin
                    m_lock = 1'b0;
                    m_cnt  = 0;
                end else begin
                    m_lock = 1'b1;
                    m_cnt  = (m_cnt < 8) ? m_cnt + 1 : 8;
                end
            end else begin
                m_cnt = 0;
            end
            m_last_dma = m_dma;
            m_ph = 2;
        end else begin
            m_ph = 0;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_inputs();
        bus.CpuReq = 0; bus.CpuWe = 0; bus.CpuAdr = '0; bus.CpuWData = '0;
        bus.DmaReq = 0; bus.DmaWe = 0; bus.DmaAdr = '0; bus.DmaWData = '0;
        bus.DmaLast = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        do_reset();

        // CPU read
        bus.CpuReq = 1; bus.CpuWe = 0; bus.CpuAdr = 32'h10;
        run(3);
        bus.CpuReq = 0;
        step();
        check("cpu_read_data", bus.CpuRData, 32'hE3A0_0005);

        // DMA write
        bus.DmaReq = 1; bus.DmaWe = 1; bus.DmaAdr = 32'h64; bus.DmaWData = 32'd7;
        run(3);
        bus.DmaReq = 0; bus.DmaWe = 0;
        step();
        check("dma_write_rdata", bus.DmaRData, 32'h0);

        // Tie after reset alternates
        do_reset();
        bus.CpuReq = 1; bus.DmaReq = 1; bus.DmaLast = 1;
        bus.CpuAdr = 32'h40; bus.DmaAdr = 32'h80;
        grants.delete();
        rec_en = 1'b1;
        run(9);
        rec_en = 1'b0;
        check("tie_grant_cnt", 32'(grants.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check("tie_grant_seq", 32'((i < grants.size()) ? grants[i] : 2'b11), 32'(exp37[i]));

        // Locked DMA burst against a waiting CPU
        do_reset();
        bus.CpuReq = 1; bus.DmaReq = 1; bus.DmaLast = 0;
        grants.delete();
        rec_en = 1'b1;
        run(30);
        bus.DmaLast = 1;
        run(9);
        rec_en = 1'b0;
        check("lock_grant_cnt", 32'(grants.size()), 32'd13);
        for (int i = 0; i < 13; i++)
            check("lock_grant_seq", 32'((i < grants.size()) ? grants[i] : 2'b11), 32'(exp38[i]));

        // Reset during a CPU write access
        clear_inputs();
        do_reset();
        bus.CpuReq = 1; bus.CpuWe = 1; bus.CpuAdr = 32'h20; bus.CpuWData = 32'h55;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.CpuReq = 0; bus.CpuWe = 0;
        run(3);

        // Request dropped in RESP, re-raised two cycles later
        bus.CpuReq = 1; bus.CpuAdr = 32'h30;
        run(2);
        bus.CpuReq = 0;
        run(2);
        bus.CpuReq = 1; bus.CpuAdr = 32'h34;
        run(3);
        bus.CpuReq = 0;
        run(2);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            reset        = ($urandom_range(99) == 0);
            bus.CpuReq   = ($urandom_range(9) < 6);
            bus.CpuWe    = $urandom_range(1);
            bus.CpuAdr   = $urandom;
            bus.CpuWData = $urandom;
            bus.DmaReq   = ($urandom_range(9) < 6);
            bus.DmaWe    = $urandom_range(1);
            bus.DmaAdr   = $urandom;
            bus.DmaWData = $urandom;
            bus.DmaLast  = ($urandom_range(3) == 0);
            step();
        end
        reset = 1'b0;
        clear_inputs();
        run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
